// File: rtl/fwnoc_pkg.sv
// Shared fwnoc router definitions: port indices, header field positions and
// the size-code decode used by both the ingress and egress managers.
package fwnoc_pkg;

  localparam logic [2:0] FWNOC_PORT_H = 3'd0;
  localparam logic [2:0] FWNOC_PORT_N = 3'd1;
  localparam logic [2:0] FWNOC_PORT_S = 3'd2;
  localparam logic [2:0] FWNOC_PORT_E = 3'd3;
  localparam logic [2:0] FWNOC_PORT_W = 3'd4;

  localparam int DST_X_MSB = 31;
  localparam int DST_X_LSB = 30;
  localparam int DST_Y_MSB = 29;
  localparam int DST_Y_LSB = 28;
  localparam int SZ_MSB    = 3;
  localparam int SZ_LSB    = 0;

  typedef enum logic [0:0] {
    EG_IDLE = 1'b0,
    EG_XFER = 1'b1
  } eg_state_e;

  // Payload words following the header; unused codes carry no payload.
  function automatic logic [4:0] fwnoc_size_decode(input logic [3:0] code);
    logic [4:0] words;
    case (code)
      4'd0:    words = 5'd0;
      4'd1:    words = 5'd1;
      4'd2:    words = 5'd2;
      4'd3:    words = 5'd4;
      4'd4:    words = 5'd8;
      4'd5:    words = 5'd16;
      default: words = 5'd0;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/fwnoc_fifo.sv
// Generic valid/ready FIFO used to buffer fwnoc links.
module fwnoc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_dat_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en_s;
  logic             rd_en_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign out_dat_o   = mem_q[rd_ptr_q];
  assign wr_en_s     = in_valid_i && in_ready_o;
  assign rd_en_s     = out_valid_o && out_ready_i;

  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= in_dat_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (rd_en_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fwnoc_rr_arb5.sv
// Five-way combinational packet arbiter. Round-robin from last_i by default;
// FWNOC_EGRESS_FIXED_PRIO_EN selects fixed priority H>N>S>E>W instead.
module fwnoc_rr_arb5
  import fwnoc_pkg::*;
(
  input  logic [4:0] req_i,
  input  logic [2:0] last_i,
  output logic       any_o,
  output logic [2:0] gnt_o
);

  logic [2:0] last_s;

`ifdef FWNOC_EGRESS_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;
  // Pretending W was last served makes the scan always start at H.
  assign last_s = FWNOC_PORT_W;
`else
  assign last_s = last_i;
`endif

  assign any_o = |req_i;

  always_comb begin
    int         idx;
    logic       found;
    logic       pick;
    logic [2:0] cand;
    gnt_o = FWNOC_PORT_H;
    found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idx   = (int'(last_s) + k) % 5;
      cand  = 3'(idx);
      pick  = !found && req_i[cand];
      gnt_o = pick ? cand : gnt_o;
      found = found | pick;
    end
  end

endmodule

// File: rtl/fwnoc_router_egress_mgr.sv
// fwnoc router egress: per-packet arbitration of five ingress paths onto one
// output link. Define FWNOC_EGRESS_FIXED_PRIO_EN for fixed-priority selection.
module fwnoc_router_egress_mgr
  import fwnoc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [31:0] h_dat,
  input  logic        n_valid,
  output logic        n_ready,
  input  logic [31:0] n_dat,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_dat,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic [31:0] e_dat,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_dat,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_dat
);

  localparam logic [3:0] unused_router_id = {2'(X_ID), 2'(Y_ID)};

  eg_state_e   state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [4:0]  rem_q, rem_d;
  logic        hdr_q, hdr_d;

  logic [4:0]  valid_s;
  logic [31:0] dat_s [5];
  logic [4:0]  ready_s;
  logic        x_valid_s;
  logic        x_ready_s;
  logic [31:0] x_dat_s;
  logic        arb_any_s;
  logic [2:0]  arb_gnt_s;
  logic        beat_s;
  logic        last_beat_s;
  logic [4:0]  size_s;

  assign valid_s  = {w_valid, e_valid, s_valid, n_valid, h_valid};
  assign dat_s[0] = h_dat;
  assign dat_s[1] = n_dat;
  assign dat_s[2] = s_dat;
  assign dat_s[3] = e_dat;
  assign dat_s[4] = w_dat;

  assign h_ready = ready_s[FWNOC_PORT_H];
  assign n_ready = ready_s[FWNOC_PORT_N];
  assign s_ready = ready_s[FWNOC_PORT_S];
  assign e_ready = ready_s[FWNOC_PORT_E];
  assign w_ready = ready_s[FWNOC_PORT_W];

  fwnoc_rr_arb5 u_arb (
    .req_i  (valid_s),
    .last_i (last_grant_q),
    .any_o  (arb_any_s),
    .gnt_o  (arb_gnt_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= EG_IDLE;
      grant_q      <= FWNOC_PORT_H;
      last_grant_q <= FWNOC_PORT_W;
      rem_q        <= 5'd0;
      hdr_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rem_q        <= rem_d;
      hdr_q        <= hdr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rem_d        = rem_q;
    hdr_d        = hdr_q;
    ready_s      = 5'b0;
    x_valid_s    = 1'b0;
    x_dat_s      = 32'h0;
    beat_s       = 1'b0;
    last_beat_s  = 1'b0;
    size_s       = 5'd0;
    case (state_q)
      EG_IDLE: begin
        if (arb_any_s) begin
          grant_d = arb_gnt_s;
          hdr_d   = 1'b1;
          state_d = EG_XFER;
        end else begin
          state_d = EG_IDLE;
        end
      end
      EG_XFER: begin
        x_valid_s        = valid_s[grant_q];
        x_dat_s          = dat_s[grant_q];
        ready_s[grant_q] = x_ready_s;
        beat_s           = x_valid_s && x_ready_s;
        size_s           = fwnoc_size_decode(x_dat_s[SZ_MSB:SZ_LSB]);
        last_beat_s      = hdr_q ? (size_s == 5'd0) : (rem_q == 5'd1);
        // Grant is held until the final payload beat, whatever stalls occur.
        if (beat_s) begin
          rem_d = hdr_q ? size_s : (rem_q - 5'd1);
          hdr_d = 1'b0;
          if (last_beat_s) begin
            last_grant_d = grant_q;
            hdr_d        = 1'b1;
            state_d      = EG_IDLE;
          end else begin
            state_d = EG_XFER;
          end
        end else begin
          state_d = EG_XFER;
        end
      end
      default: begin
        state_d = EG_IDLE;
      end
    endcase
  end

  generate
    if (FIFO_DEPTH == 0) begin : g_bypass
      assign o_valid   = x_valid_s;
      assign o_dat     = x_dat_s;
      assign x_ready_s = o_ready;
    end else begin : g_fifo
      fwnoc_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (x_valid_s),
        .in_ready_o  (x_ready_s),
        .in_dat_i    (x_dat_s),
        .out_valid_o (o_valid),
        .out_ready_i (o_ready),
        .out_dat_o   (o_dat)
      );
    end
  endgenerate

endmodule
